// File: rtl/serial_readout_pkg.sv
// Shared types and constants for the serial readout port.
// SERIAL_READOUT_STATUS_EN adds a leading 'fresh' flag bit to every frame.
package serial_readout_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam int DATA_W_DEFAULT = 12;

`ifdef SERIAL_READOUT_STATUS_EN
  localparam int STATUS_W = 1;
`else
  localparam int STATUS_W = 0;
`endif

  localparam int FRAME_W_DEFAULT = DATA_W_DEFAULT + STATUS_W;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop bit synchroniser with a configurable depth and reset value.
module sync_ff #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= {DEPTH{RST_VAL}};
    else        ff <= {ff[DEPTH-2:0], d};
  end

  assign q = ff[DEPTH-1];

endmodule

// File: rtl/serial_readout.sv
// Slave serial readout: shadows each filter result and shifts it out MSB-first
// under an asynchronous cs_n/sclk master. SERIAL_READOUT_STATUS_EN prepends a fresh flag.
module serial_readout
  import serial_readout_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] data_in,
  input  logic              new_data,
  input  logic              sclk,
  input  logic              cs_n,
  output logic              serial_data_out,
  output logic              busy
);

  localparam int FRAME_W = DATA_W + STATUS_W;
  localparam int CNT_W   = $clog2(FRAME_W);

  logic sclk_s, sclk_d, cs_n_s, cs_n_d;
  logic sclk_rise, cs_fall, cs_rise;

  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk), .q(sclk_s));
  sync_ff #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d(cs_n), .q(cs_n_s));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_d <= 1'b0;
      cs_n_d <= 1'b1;
    end else begin
      sclk_d <= sclk_s;
      cs_n_d <= cs_n_s;
    end
  end

  assign sclk_rise = sclk_s & ~sclk_d;
  assign cs_fall   = ~cs_n_s & cs_n_d;
  assign cs_rise   = cs_n_s & ~cs_n_d;
  assign busy      = ~cs_n_s;

  // Capture once per strobe, on its rising edge.
  logic              nd_d, cap;
  logic [DATA_W-1:0] shadow, load_data;

  assign cap       = new_data & ~nd_d;
  assign load_data = cap ? data_in : shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nd_d   <= 1'b0;
      shadow <= '0;
    end else begin
      nd_d <= new_data;
      if (cap) shadow <= data_in;
    end
  end

  state_t             state, state_nxt;
  logic [FRAME_W-1:0] shreg, shreg_nxt, load_word;
  logic [CNT_W-1:0]   bitcnt, bitcnt_nxt;
  logic               sdo_nxt;

`ifdef SERIAL_READOUT_STATUS_EN
  logic fresh;

  // A capture landing in the LOAD cycle is itself new data, so it stays fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              fresh <= 1'b0;
    else if (cap)            fresh <= 1'b1;
    else if (state == LOAD)  fresh <= 1'b0;
  end

  assign load_word = {fresh | cap, load_data};
`else
  assign load_word = load_data;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      shreg           <= '0;
      bitcnt          <= '0;
      serial_data_out <= 1'b0;
    end else begin
      state           <= state_nxt;
      shreg           <= shreg_nxt;
      bitcnt          <= bitcnt_nxt;
      serial_data_out <= sdo_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    bitcnt_nxt = bitcnt;
    case (state)
      IDLE: if (cs_fall) state_nxt = LOAD;
      LOAD: begin
        shreg_nxt  = load_word;
        bitcnt_nxt = CNT_W'(FRAME_W - 1);
        state_nxt  = SHIFT;
      end
      SHIFT: if (sclk_rise) begin
        shreg_nxt  = shreg << 1;
        bitcnt_nxt = bitcnt - CNT_W'(1);
        if (bitcnt == '0) state_nxt = DONE;
      end
      default: ;
    endcase
    if (cs_rise) state_nxt = IDLE;
    // Output is registered from next-state values so no input reaches it combinationally.
    sdo_nxt = (state_nxt == SHIFT) ? shreg_nxt[FRAME_W-1] : 1'b0;
  end

endmodule

// File: tb/tb_serial_readout.sv
// Directed bench for serial_readout: reset, readout, mid-frame update, abort,
// LOAD bypass, fresh flag, and reset mid-frame.
module tb_serial_readout;

  localparam int DW = 12;
`ifdef SERIAL_READOUT_STATUS_EN
  localparam int FW = 13;
`else
  localparam int FW = 12;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          new_data = 1'b0;
  logic          sclk = 1'b0;
  logic          cs_n = 1'b1;
  logic          sdo, busy;
  logic [15:0]   w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_readout #(.DATA_W(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .new_data(new_data),
    .sclk(sclk), .cs_n(cs_n), .serial_data_out(sdo), .busy(busy));

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [15:0] fexp(input logic flag, input logic [11:0] d);
    if (FW == 13) return {3'b000, flag, d};
    return {4'b0000, d};
  endfunction

  task automatic load(input logic [11:0] val, input int len);
    data_in = val; new_data = 1'b1; cyc(len);
    new_data = 1'b0; cyc(2);
  endtask

  // upd_at<0 pulses new_data in the LOAD cycle; otherwise in the low phase after bit upd_at.
  task automatic frame(input int nclk, input int upd_at, input logic [11:0] upd_val,
                       input int extra, output logic [15:0] word);
    word = '0;
    cs_n = 1'b0;
    if (upd_at < 0) begin
      cyc(3);
      data_in = upd_val; new_data = 1'b1; cyc(1);
      new_data = 1'b0; cyc(1);
    end else cyc(5);
    chk("busy_frame", {15'd0, busy}, 16'd1);
    for (int i = 0; i < nclk; i++) begin
      word = {word[14:0], sdo};
      sclk = 1'b1; cyc(5);
      sclk = 1'b0;
      if (i == upd_at) begin
        data_in = upd_val; new_data = 1'b1; cyc(1);
        new_data = 1'b0; cyc(4);
      end else cyc(5);
    end
    if (nclk == FW) chk("sdo_done", {15'd0, sdo}, 16'd0);
    for (int i = 0; i < extra; i++) begin
      sclk = 1'b1; cyc(5);
      sclk = 1'b0; cyc(5);
      chk("sdo_extra", {15'd0, sdo}, 16'd0);
    end
    cs_n = 1'b1; cyc(4);
    chk("busy_fall", {15'd0, busy}, 16'd0);
    cyc(4);
  endtask

  initial begin
    // Reset held while the master toggles its lines.
    for (int i = 0; i < 8; i++) begin
      sclk = i[0]; cs_n = i[1];
      cyc(1);
      chk("rst_sdo", {15'd0, sdo}, 16'd0);
      chk("rst_busy", {15'd0, busy}, 16'd0);
    end
    sclk = 1'b0; cs_n = 1'b1;
    cyc(1); rst_n = 1'b1; cyc(5);

    // Basic readout with a 2-cycle strobe and extra clocks in DONE.
    load(12'hA5C, 2);
    frame(FW, 99, 12'h000, 2, w);
    chk("basic", w, fexp(1'b1, 12'hA5C));

    // Shadow update mid-frame does not disturb the frame in flight.
    load(12'h0FF, 1);
    frame(FW, 3, 12'hF00, 0, w);
    chk("upd_cur", w, fexp(1'b1, 12'h0FF));
    frame(FW, 99, 12'h000, 0, w);
    chk("upd_next", w, fexp(1'b1, 12'hF00));

    // Abort after 3 bits; next frame restarts from the MSB.
    load(12'h801, 1);
    frame(3, 99, 12'h000, 0, w);
    frame(FW, 99, 12'h000, 0, w);
    chk("abort", w, fexp(1'b0, 12'h801));

    // Capture coinciding with LOAD is bypassed into the frame.
    frame(FW, -1, 12'h123, 0, w);
    chk("bypass", w, fexp(1'b1, 12'h123));

    // Fresh flag set once, cleared by the first read.
    load(12'h3C3, 1);
    frame(FW, 99, 12'h000, 0, w);
    chk("fresh1", w, fexp(1'b1, 12'h3C3));
    frame(FW, 99, 12'h000, 0, w);
    chk("fresh0", w, fexp(1'b0, 12'h3C3));

    // Reset mid-frame clears output immediately and zeroes the shadow.
    load(12'hFFF, 1);
    cs_n = 1'b0; cyc(5);
    sclk = 1'b1; cyc(5); sclk = 1'b0; cyc(2);
    rst_n = 1'b0; #1;
    chk("rstmid_sdo", {15'd0, sdo}, 16'd0);
    chk("rstmid_busy", {15'd0, busy}, 16'd0);
    cs_n = 1'b1; cyc(3);
    rst_n = 1'b1; cyc(5);
    chk("post_rst_sdo", {15'd0, sdo}, 16'd0);
    frame(FW, 99, 12'h000, 0, w);
    chk("post_rst_frame", w, fexp(1'b0, 12'h000));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
